core_mem_arbiter: RTL and testbench

- Two-into-one arbiter. Shares a single memory port between the core's instruction fetch interface (imem_*) and data interface (dmem_*).
- Sits between core_top and a unified single-ported memory/bus, on the same req/gnt/err/rdata protocol.
- Holds stable arbitration while a request stalls.
- Routes each response back to the requester that was granted.
- Prevents fetch starvation under sustained data traffic.

---
 rtl/core_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory port between instruction fetch (imem)
// and data (dmem) requesters on a req/gnt/err/rdata protocol.
// The owner is held while a request stalls, and responses are routed back to
// the requester that was granted one cycle earlier.
// Optional build macro CORE_MEM_ARBITER_ROUND_ROBIN_EN: alternate between
// requesters on contention instead of fixed dmem priority with the
// starvation override.
module core_mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STRB_W       = DATA_W / 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_wen,
    input  logic [STRB_W-1:0] imem_strb,
    input  logic [DATA_W-1:0] imem_wdata,
    output logic              imem_gnt,
    output logic              imem_err,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic              dmem_req,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_wen,
    input  logic [STRB_W-1:0] dmem_strb,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_gnt,
    output logic              dmem_err,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [STRB_W-1:0] mem_strb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_err,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_owner
);

    // Owner encoding: 0 = imem, 1 = dmem.
    logic lock_q, lock_d;
    logic lock_owner_q, lock_owner_d;
    logic rsp_v_q, rsp_v_d;
    logic rsp_o_q, rsp_o_d;
    logic arb_owner_q, arb_owner_d;
    logic owner;
    logic lock_live;
    logic accept;

    // A lock only holds while its owner still requests; a dropped request
    // releases it so arbitration can happen in that same cycle.
    assign lock_live = lock_q && (lock_owner_q ? dmem_req : imem_req);

`ifdef CORE_MEM_ARBITER_ROUND_ROBIN_EN
    logic last_gnt_q, last_gnt_d;

    // Owner selection: lock, then alternate on contention, then single requester.
    always_comb begin
        owner = arb_owner_q;
        if (lock_live) begin
            owner = lock_owner_q;
        end else if (dmem_req && imem_req) begin
            owner = ~last_gnt_q;
        end else if (dmem_req) begin
            owner = 1'b1;
        end else if (imem_req) begin
            owner = 1'b0;
        end
    end

    // Remember which side won the most recent accept.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (accept) begin
            last_gnt_d = owner;
        end
    end

    // Last-granted register.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    localparam int CTR_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CTR_W-1:0] LIMIT_C = CTR_W'(STARVE_LIMIT);

    logic [CTR_W-1:0] starve_ctr_q, starve_ctr_d;
    logic             starve_hit;

    assign starve_hit = (STARVE_LIMIT != 0) && (starve_ctr_q == LIMIT_C) && imem_req;

    // Owner selection: lock, starvation override, dmem priority, imem, hold.
    always_comb begin
        owner = arb_owner_q;
        if (lock_live) begin
            owner = lock_owner_q;
        end else if (starve_hit) begin
            owner = 1'b0;
        end else if (dmem_req) begin
            owner = 1'b1;
        end else if (imem_req) begin
            owner = 1'b0;
        end
    end

    // Count consecutive cycles imem waits without a grant, saturating.
    always_comb begin
        starve_ctr_d = starve_ctr_q;
        if (!imem_req || imem_gnt) begin
            starve_ctr_d = '0;
        end else if (starve_ctr_q != LIMIT_C) begin
            starve_ctr_d = starve_ctr_q + CTR_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_ctr_q <= '0;
        end else begin
            starve_ctr_q <= starve_ctr_d;
        end
    end
`endif

    // Request/payload mux and grant/response routing; reset blanks all strobes.
    always_comb begin
        mem_req    = !reset && (owner ? dmem_req : imem_req);
        mem_addr   = owner ? dmem_addr  : imem_addr;
        mem_wen    = owner ? dmem_wen   : imem_wen;
        mem_strb   = owner ? dmem_strb  : imem_strb;
        mem_wdata  = owner ? dmem_wdata : imem_wdata;
        imem_gnt   = !reset && mem_gnt && !owner && imem_req;
        dmem_gnt   = !reset && mem_gnt &&  owner && dmem_req;
        imem_rdata = (!reset && rsp_v_q && !rsp_o_q) ? mem_rdata : '0;
        dmem_rdata = (!reset && rsp_v_q &&  rsp_o_q) ? mem_rdata : '0;
        imem_err   = !reset && mem_err && rsp_v_q && !rsp_o_q;
        dmem_err   = !reset && mem_err && rsp_v_q &&  rsp_o_q;
        arb_owner  = owner;
    end

    assign accept = mem_req && mem_gnt;

    // Next-state for lock, response tracking and the remembered owner.
    always_comb begin
        lock_d       = mem_req && !mem_gnt;
        lock_owner_d = owner;
        rsp_v_d      = accept;
        rsp_o_d      = owner;
        arb_owner_d  = owner;
    end

    // Arbitration state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            rsp_v_q      <= 1'b0;
            rsp_o_q      <= 1'b0;
            arb_owner_q  <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            rsp_v_q      <= rsp_v_d;
            rsp_o_q      <= rsp_o_d;
            arb_owner_q  <= arb_owner_d;
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed testbench for core_mem_arbiter (default parameters).
module tb_core_mem_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    logic              clock;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_wen;
    logic [STRB_W-1:0] imem_strb;
    logic [DATA_W-1:0] imem_wdata;
    logic              imem_gnt;
    logic              imem_err;
    logic [DATA_W-1:0] imem_rdata;
    logic              dmem_req;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_wen;
    logic [STRB_W-1:0] dmem_strb;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_err;
    logic [DATA_W-1:0] dmem_rdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [STRB_W-1:0] mem_strb;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_err;
    logic [DATA_W-1:0] mem_rdata;
    logic              arb_owner;

    int vectors;
    int miscompares;

    core_mem_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_wen   (imem_wen),
        .imem_strb  (imem_strb),
        .imem_wdata (imem_wdata),
        .imem_gnt   (imem_gnt),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_err   (dmem_err),
        .dmem_rdata (dmem_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata),
        .arb_owner  (arb_owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        mem_gnt   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_req = 1'b1; dmem_req = 1'b1; mem_gnt = 1'b1;
        mem_err = 1'b1; mem_rdata = 64'h55;
        step(); step();
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        vectors++;
        if (imem_gnt !== 1'b0 || dmem_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt: got i=%b d=%b expected 0/0", imem_gnt, dmem_gnt); end
        vectors++;
        if (imem_rdata !== 64'h0 || dmem_err !== 1'b0 || imem_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp: got rdata=%h ierr=%b derr=%b expected 0", imem_rdata, imem_err, dmem_err); end
        idle();
        reset = 1'b0;
        step();
        #1;
        vectors++;
        if (arb_owner !== 1'b0) begin miscompares++; $display("FAIL reset_owner: got %b expected 0", arb_owner); end
        $display("test_reset done");
    endtask

    task automatic test_imem_single();
        imem_req = 1'b1; mem_gnt = 1'b1;
        #1;
        vectors++;
        if (imem_gnt !== 1'b1 || dmem_gnt !== 1'b0) begin miscompares++; $display("FAIL single_gnt: got i=%b d=%b expected 1/0", imem_gnt, dmem_gnt); end
        vectors++;
        if (mem_addr !== 64'h1000 || mem_req !== 1'b1) begin miscompares++; $display("FAIL single_addr: got %h req=%b expected 1000 req=1", mem_addr, mem_req); end
        step();
        imem_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 64'hDEAD;
        #1;
        vectors++;
        if (imem_rdata !== 64'hDEAD) begin miscompares++; $display("FAIL single_irdata: got %h expected dead", imem_rdata); end
        vectors++;
        if (dmem_rdata !== 64'h0) begin miscompares++; $display("FAIL single_drdata: got %h expected 0", dmem_rdata); end
        step();
        idle();
        step();
        $display("test_imem_single done");
    endtask

`ifndef CORE_MEM_ARBITER_ROUND_ROBIN_EN
    task automatic test_starvation();
        logic exp_owner;
        imem_req = 1'b1; dmem_req = 1'b1; mem_gnt = 1'b1;
        for (int c = 0; c < 18; c++) begin
            #1;
            exp_owner = (c == 8 || c == 17) ? 1'b0 : 1'b1;
            vectors++;
            if (dmem_gnt !== exp_owner || imem_gnt !== !exp_owner) begin
                miscompares++;
                $display("FAIL starve_cycle%0d: got i=%b d=%b expected i=%b d=%b", c, imem_gnt, dmem_gnt, !exp_owner, exp_owner);
            end
            step();
        end
        idle();
        step();
        $display("test_starvation done");
    endtask
`else
    task automatic test_round_robin();
        logic exp_owner;
        imem_req = 1'b1; dmem_req = 1'b1; mem_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_owner = (c % 2 == 0) ? 1'b1 : 1'b0;
            vectors++;
            if (dmem_gnt !== exp_owner || imem_gnt !== !exp_owner) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: got i=%b d=%b expected i=%b d=%b", c, imem_gnt, dmem_gnt, !exp_owner, exp_owner);
            end
            step();
        end
        idle();
        step();
        $display("test_round_robin done");
    endtask
`endif

    task automatic test_stall_lock();
        dmem_req = 1'b1; mem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) imem_req = 1'b1;
            #1;
            vectors++;
            if (mem_addr !== 64'h2000 || dmem_gnt !== 1'b0 || imem_gnt !== 1'b0 || arb_owner !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_cycle%0d: got addr=%h dg=%b ig=%b own=%b expected 2000 0 0 1", c, mem_addr, dmem_gnt, imem_gnt, arb_owner);
            end
            step();
        end
        mem_gnt = 1'b1;
        #1;
        vectors++;
        if (dmem_gnt !== 1'b1 || mem_addr !== 64'h2000 || mem_wdata !== 64'hD0D0) begin miscompares++; $display("FAIL stall_release: got dg=%b addr=%h wdata=%h expected 1 2000 d0d0", dmem_gnt, mem_addr, mem_wdata); end
        step();
        dmem_req = 1'b0;
        #1;
        vectors++;
        if (imem_gnt !== 1'b1 || mem_addr !== 64'h1000) begin miscompares++; $display("FAIL stall_next_imem: got ig=%b addr=%h expected 1 1000", imem_gnt, mem_addr); end
        step();
        idle();
        step();
        $display("test_stall_lock done");
    endtask

    task automatic test_lock_drop();
        dmem_req = 1'b1; mem_gnt = 1'b0;
        step();
        dmem_req = 1'b0; imem_req = 1'b1; mem_gnt = 1'b1;
        #1;
        vectors++;
        if (imem_gnt !== 1'b1 || arb_owner !== 1'b0) begin miscompares++; $display("FAIL lock_drop: got ig=%b own=%b expected 1 0", imem_gnt, arb_owner); end
        step();
        idle();
        step();
        $display("test_lock_drop done");
    endtask

    task automatic test_back_to_back();
        dmem_req = 1'b1; mem_gnt = 1'b1;
        #1;
        vectors++;
        if (dmem_gnt !== 1'b1) begin miscompares++; $display("FAIL b2b_dgnt: got %b expected 1", dmem_gnt); end
        step();
        dmem_req = 1'b0; imem_req = 1'b1; mem_err = 1'b1; mem_rdata = 64'hA1;
        #1;
        vectors++;
        if (dmem_err !== 1'b1 || dmem_rdata !== 64'hA1) begin miscompares++; $display("FAIL b2b_drsp: got err=%b rdata=%h expected 1 a1", dmem_err, dmem_rdata); end
        vectors++;
        if (imem_err !== 1'b0 || imem_rdata !== 64'h0 || imem_gnt !== 1'b1) begin miscompares++; $display("FAIL b2b_iside: got err=%b rdata=%h gnt=%b expected 0 0 1", imem_err, imem_rdata, imem_gnt); end
        step();
        imem_req = 1'b0; mem_gnt = 1'b0; mem_err = 1'b0; mem_rdata = 64'hB2;
        #1;
        vectors++;
        if (imem_rdata !== 64'hB2 || imem_err !== 1'b0 || dmem_rdata !== 64'h0 || dmem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_irsp: got i=%h ie=%b d=%h de=%b expected b2 0 0 0", imem_rdata, imem_err, dmem_rdata, dmem_err);
        end
        step();
        mem_err = 1'b1;
        #1;
        vectors++;
        if (imem_err !== 1'b0 || dmem_err !== 1'b0) begin miscompares++; $display("FAIL b2b_noresp_err: got ie=%b de=%b expected 0 0", imem_err, dmem_err); end
        idle();
        step();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_outstanding();
        imem_req = 1'b1; mem_gnt = 1'b1;
        #1;
        vectors++;
        if (imem_gnt !== 1'b1) begin miscompares++; $display("FAIL rst_out_gnt: got %b expected 1", imem_gnt); end
        step();
        reset = 1'b1; imem_req = 1'b0; dmem_req = 1'b1; mem_rdata = 64'hCC; mem_err = 1'b1;
        #1;
        vectors++;
        if (imem_rdata !== 64'h0 || imem_err !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_out_during: got rdata=%h err=%b req=%b expected 0 0 0", imem_rdata, imem_err, mem_req); end
        step();
        reset = 1'b0; dmem_req = 1'b0;
        #1;
        vectors++;
        if (imem_rdata !== 64'h0 || imem_err !== 1'b0 || dmem_rdata !== 64'h0 || dmem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_out_after: got i=%h ie=%b d=%h de=%b expected 0", imem_rdata, imem_err, dmem_rdata, dmem_err);
        end
        imem_req = 1'b1; mem_err = 1'b0;
        #1;
        vectors++;
        if (imem_gnt !== 1'b1 || mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_out_regrant: got gnt=%b req=%b expected 1 1", imem_gnt, mem_req); end
        step();
        imem_req = 1'b0; mem_gnt = 1'b0;
        #1;
        vectors++;
        if (imem_rdata !== 64'hCC) begin miscompares++; $display("FAIL rst_out_rsp: got %h expected cc", imem_rdata); end
        idle();
        step();
        $display("test_reset_outstanding done");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        imem_addr = 64'h1000; imem_wen = 1'b0; imem_strb = 8'h00; imem_wdata = 64'h1111;
        dmem_addr = 64'h2000; dmem_wen = 1'b1; dmem_strb = 8'hFF; dmem_wdata = 64'hD0D0;
        idle();
        reset = 1'b1;
        test_reset();
        test_imem_single();
`ifndef CORE_MEM_ARBITER_ROUND_ROBIN_EN
        test_starvation();
`endif
        test_stall_lock();
        test_lock_drop();
        test_back_to_back();
        test_reset_outstanding();
`ifdef CORE_MEM_ARBITER_ROUND_ROBIN_EN
        test_round_robin();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
